// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
// Shares one binary-to-Gray converter between N_REQ requesters.
// Arbitration is round-robin, and each transaction returns one tagged result.
//
// Handshake contract:
//   - A requester raises req[k] and holds din[k] stable until it is granted.
//   - The operand is captured on the grant edge, and gnt[k] stays high for WAIT and DONE.
//   - ack[k] and dout_vld pulse together for one cycle, with dout and dout_id valid.
//   - The requester drops req[k] by the cycle after ack, because IDLE samples
//     req again in that cycle.
//   - Dropping req while WAIT is in progress does not cancel the transaction.
//   - Only one transaction is ever in flight, and busy is high outside IDLE.
module gray_conv_arbiter #(
  parameter int WIDTH    = 4,
  parameter int N_REQ    = 4,
  parameter int CONV_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   din,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         ack,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(N_REQ)-1:0] dout_id,
  output logic                     dout_vld,
  output logic                     busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [ID_W-1:0]   win, win_nxt;
  logic [ID_W-1:0]   pick;
  logic [WIDTH-1:0]  op, op_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [N_REQ-1:0]  gnt_nxt, ack_nxt;
  logic [WIDTH-1:0]  dout_nxt;
  logic [ID_W-1:0]   dout_id_nxt;
  logic              vld_nxt;

  // First requester at or after p, wrapping modulo N_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  p);
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] k;
    logic            found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = ID_W'((int'(p) + i) % N_REQ);
      if (!found && r[k]) begin
        sel   = k;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick = rr_pick(req, ptr);
  assign busy = (state != IDLE);

  // Next-state and next-output logic. Pulses default low, and everything else holds.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    win_nxt     = win;
    op_nxt      = op;
    cnt_nxt     = cnt;
    gnt_nxt     = gnt;
    ack_nxt     = '0;
    dout_nxt    = dout;
    dout_id_nxt = dout_id;
    vld_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          op_nxt    = din[pick*WIDTH +: WIDTH];
          win_nxt   = pick;
          gnt_nxt   = N_REQ'(1) << pick;
          cnt_nxt   = CNT_W'(CONV_LAT - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          dout_nxt    = op ^ (op >> 1);
          dout_id_nxt = win;
          vld_nxt     = 1'b1;
          ack_nxt     = N_REQ'(1) << win;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        gnt_nxt   = '0;
        ptr_nxt   = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers. Reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      op       <= '0;
      cnt      <= '0;
      gnt      <= '0;
      ack      <= '0;
      dout     <= '0;
      dout_id  <= '0;
      dout_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      win      <= win_nxt;
      op       <= op_nxt;
      cnt      <= cnt_nxt;
      gnt      <= gnt_nxt;
      ack      <= ack_nxt;
      dout     <= dout_nxt;
      dout_id  <= dout_id_nxt;
      dout_vld <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter.
// dut_a uses CONV_LAT=1 and dut_b uses CONV_LAT=3.
// Both instances share the clock and the reset.
module tb_gray_conv_arbiter;

  localparam int W = 4;
  localparam int N = 4;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req_a, gnt_a, ack_a, req_b, gnt_b, ack_b;
  logic [N*W-1:0] din_a, din_b;
  logic [W-1:0]   dout_a, dout_b;
  logic [1:0]     dout_id_a, dout_id_b;
  logic           vld_a, busy_a, vld_b, busy_b;

  gray_conv_arbiter #(.WIDTH(W), .N_REQ(N), .CONV_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .din(din_a), .gnt(gnt_a), .ack(ack_a),
    .dout(dout_a), .dout_id(dout_id_a), .dout_vld(vld_a), .busy(busy_a)
  );

  gray_conv_arbiter #(.WIDTH(W), .N_REQ(N), .CONV_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .din(din_b), .gnt(gnt_b), .ack(ack_b),
    .dout(dout_b), .dout_id(dout_id_b), .dout_vld(vld_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard entries are {id, gray}.
  logic [5:0] exp_a_q[$];
  logic [5:0] exp_b_q[$];

  // Gray code built bit by bit from its definition.
  function automatic logic [3:0] to_gray(input logic [3:0] b);
    logic [3:0] g;
    g[3] = b[3];
    for (int i = 0; i < 3; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  // Scoreboard for dut_a: pop one entry on each dout_vld and check dout, dout_id and ack.
  always @(negedge clk) begin
    logic [5:0] e;
    logic [3:0] ack_exp;
    if (!rst && vld_a) begin
      n_checks++;
      if (exp_a_q.size() == 0) begin
        $display("FAIL sb_a unexpected result id=%0d dout=%b", dout_id_a, dout_a);
      end else begin
        e = exp_a_q.pop_front();
        ack_exp = 4'b0001 << e[5:4];
        if ({dout_id_a, dout_a} !== e || ack_a !== ack_exp)
          $display("FAIL sb_a got id=%0d dout=%b ack=%b, want id=%0d dout=%b ack=%b",
                   dout_id_a, dout_a, ack_a, e[5:4], e[3:0], ack_exp);
        else n_pass++;
      end
    end
  end

  // Scoreboard for dut_b: pop one entry on each dout_vld and check dout, dout_id and ack.
  always @(negedge clk) begin
    logic [5:0] e;
    logic [3:0] ack_exp;
    if (!rst && vld_b) begin
      n_checks++;
      if (exp_b_q.size() == 0) begin
        $display("FAIL sb_b unexpected result id=%0d dout=%b", dout_id_b, dout_b);
      end else begin
        e = exp_b_q.pop_front();
        ack_exp = 4'b0001 << e[5:4];
        if ({dout_id_b, dout_b} !== e || ack_b !== ack_exp)
          $display("FAIL sb_b got id=%0d dout=%b ack=%b, want id=%0d dout=%b ack=%b",
                   dout_id_b, dout_b, ack_b, e[5:4], e[3:0], ack_exp);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    logic bad;
    rst = 1'b1; req_a = '0; req_b = '0; din_a = '0; din_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({gnt_a, ack_a, dout_a, dout_id_a, vld_a, busy_a} !== 16'h0)
      $display("FAIL reset_a got %h want 0", {gnt_a, ack_a, dout_a, dout_id_a, vld_a, busy_a});
    else n_pass++;
    // Start a dut_b transaction and reset it while it is in WAIT.
    req_b = 4'b0001; din_b = 16'h0006;
    @(negedge clk);
    n_checks++;
    if (gnt_b !== 4'b0001 || busy_b !== 1'b1)
      $display("FAIL reset_b_grant got gnt=%b busy=%b want 0001/1", gnt_b, busy_b);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1; req_b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({gnt_b, ack_b, dout_b, dout_id_b, vld_b, busy_b} !== 16'h0)
      $display("FAIL reset_mid_wait got %h want 0", {gnt_b, ack_b, dout_b, dout_id_b, vld_b, busy_b});
    else n_pass++;
    rst = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack_b !== 4'b0 || vld_b !== 1'b0 || busy_b !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL reset_dropped_ack got ack/vld/busy activity want none");
    else n_pass++;
  endtask

  task automatic test_single();
    req_a = 4'b0001; din_a = {12'h000, 4'b1010};
    exp_a_q.push_back({2'd0, 4'b1111});
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 4'b0001 || busy_a !== 1'b1 || vld_a !== 1'b0)
      $display("FAIL single_grant got gnt=%b busy=%b vld=%b want 0001/1/0", gnt_a, busy_a, vld_a);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (vld_a !== 1'b1 || gnt_a !== 4'b0001)
      $display("FAIL single_done got vld=%b gnt=%b want 1/0001", vld_a, gnt_a);
    else n_pass++;
    if (|ack_a) req_a = req_a & ~ack_a;
    @(negedge clk);
    n_checks++;
    if ({gnt_a, ack_a, vld_a, busy_a, dout_a} !== {4'b0, 4'b0, 1'b0, 1'b0, 4'b1111})
      $display("FAIL single_idle got gnt=%b ack=%b vld=%b busy=%b dout=%b want 0/0/0/0/1111",
               gnt_a, ack_a, vld_a, busy_a, dout_a);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [3:0] bin_t [4];
    logic [3:0] gry_t [4];
    int vcnt;
    bin_t = '{4'b0000, 4'b1000, 4'b1111, 4'b0111};
    gry_t = '{4'b0000, 4'b1100, 4'b1000, 4'b0100};
    for (int v = 0; v < 4; v++) begin
      din_a = {12'($urandom), bin_t[v]};
      req_a = 4'b0001;
      exp_a_q.push_back({2'd0, gry_t[v]});
      vcnt = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (vld_a === 1'b1) vcnt++;
        if (|ack_a) req_a = req_a & ~ack_a;
      end
      n_checks++;
      if (vcnt != 1) $display("FAIL sweep_vld_width v=%0d got %0d cycles want 1", v, vcnt);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] prev;
    logic [7:0] order;
    int n_g, n_v;
    int vcyc [4];
    logic ok;
    rst = 1'b1; req_a = '0;
    @(negedge clk);
    rst = 1'b0;
    din_a = 16'($urandom);
    for (int k = 0; k < 4; k++) exp_a_q.push_back({2'(k), to_gray(din_a[k*4 +: 4])});
    req_a = 4'hF;
    prev = '0; order = '0; n_g = 0; n_v = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (gnt_a != 4'b0 && prev == 4'b0) begin
        n_g++;
        for (int k = 0; k < 4; k++) if (gnt_a[k]) order = {order[5:0], 2'(k)};
      end
      prev = gnt_a;
      if (vld_a === 1'b1) begin
        if (n_v < 4) vcyc[n_v] = c;
        n_v++;
      end
      if (|ack_a) req_a = req_a & ~ack_a;
    end
    n_checks++;
    if (n_g != 4 || order !== 8'h1B)
      $display("FAIL rr_order got n=%0d order=%h want 4/1b", n_g, order);
    else n_pass++;
    ok = (n_v == 4);
    if (ok) for (int i = 1; i < 4; i++) if (vcyc[i] - vcyc[i-1] != 3) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL rr_spacing got %0d results, want 4 spaced 3 cycles apart", n_v);
    else n_pass++;
    // After the grant to 3 the pointer wraps to 0, so 0 beats 3.
    din_a = 16'($urandom);
    exp_a_q.push_back({2'd0, to_gray(din_a[3:0])});
    req_a = 4'b1001;
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 4'b0001) $display("FAIL rr_wrap got gnt=%b want 0001", gnt_a);
    else n_pass++;
    req_a = 4'b0001;
    repeat (3) begin
      @(negedge clk);
      if (|ack_a) req_a = req_a & ~ack_a;
    end
  endtask

  task automatic test_alternation();
    logic [3:0] prev, pend;
    logic [7:0] order;
    int n_g, n_ack;
    din_a = 16'($urandom);
    for (int i = 0; i < 2; i++) begin
      exp_a_q.push_back({2'd1, to_gray(din_a[7:4])});
      exp_a_q.push_back({2'd3, to_gray(din_a[15:12])});
    end
    req_a = 4'b1010;
    prev = '0; pend = '0; order = '0; n_g = 0; n_ack = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_a = req_a | pend;
      pend = '0;
      if (gnt_a != 4'b0 && prev == 4'b0) begin
        n_g++;
        for (int k = 0; k < 4; k++) if (gnt_a[k]) order = {order[5:0], 2'(k)};
      end
      prev = gnt_a;
      if (|ack_a) begin
        n_ack++;
        req_a = req_a & ~ack_a;
        if (n_ack < 3) pend = ack_a;
      end
    end
    n_checks++;
    if (n_g != 4 || order !== 8'b01_11_01_11)
      $display("FAIL alternation got n=%0d order=%b want 4/01110111", n_g, order);
    else n_pass++;
  endtask

  task automatic test_latency3();
    logic [7:0] busy_h, gnt_h, ack_h;
    busy_h = '0; gnt_h = '0; ack_h = '0;
    din_b = {12'h000, 4'b0110};
    req_b = 4'b0001;
    exp_b_q.push_back({2'd0, 4'b0101});
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      busy_h[c] = busy_b;
      gnt_h[c]  = gnt_b[0];
      ack_h[c]  = ack_b[0];
      if (c == 2) din_b = {12'hFFF, 4'b1001};
      if (|ack_b) req_b = req_b & ~ack_b;
    end
    n_checks++;
    if (busy_h !== 8'b0001_1110) $display("FAIL lat3_busy got %b want 00011110", busy_h);
    else n_pass++;
    n_checks++;
    if (ack_h !== 8'b0001_0000) $display("FAIL lat3_ack got %b want 00010000", ack_h);
    else n_pass++;
    n_checks++;
    if (gnt_h !== 8'b0001_1110) $display("FAIL lat3_gnt got %b want 00011110", gnt_h);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_round_robin();
    test_alternation();
    test_latency3();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_a_q.size() != 0) $display("FAIL sb_a_drain got %0d left want 0", exp_a_q.size());
    else n_pass++;
    n_checks++;
    if (exp_b_q.size() != 0) $display("FAIL sb_b_drain got %0d left want 0", exp_b_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
